// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants and types for the ALU_ACC command sequencer
//
// Purpose : opcode values, ALU_ACC C-line bit positions, FSM state encoding,
//           latency counter width and the opcode -> C-line decode helper.
// Ports   : none (package).

package alu_seq_pkg;

  localparam int LAT_W  = 4;
  localparam int CTRL_W = 10;

  localparam logic [3:0] OP_CLR  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LAST = 4'd9;

  localparam int CTRL_C8  = 0;
  localparam int CTRL_C9  = 1;
  localparam int CTRL_C13 = 2;
  localparam int CTRL_C15 = 3;
  localparam int CTRL_C16 = 4;
  localparam int CTRL_C17 = 5;
  localparam int CTRL_C18 = 6;
  localparam int CTRL_C19 = 7;
  localparam int CTRL_C20 = 8;
  localparam int CTRL_C21 = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Illegal opcodes decode to all-zero so no C-line can ever fire for them.
  function automatic logic [CTRL_W-1:0] op_onehot(input logic [3:0] op);
    logic [CTRL_W-1:0] v;
    v = '0;
    case (op)
      OP_CLR:  v[CTRL_C8]  = 1'b1;
      OP_ADD:  v[CTRL_C9]  = 1'b1;
      OP_SUB:  v[CTRL_C13] = 1'b1;
      OP_MUL:  v[CTRL_C15] = 1'b1;
      OP_DIV:  v[CTRL_C16] = 1'b1;
      OP_SHR:  v[CTRL_C17] = 1'b1;
      OP_SHL:  v[CTRL_C18] = 1'b1;
      OP_AND:  v[CTRL_C19] = 1'b1;
      OP_OR:   v[CTRL_C20] = 1'b1;
      OP_NOT:  v[CTRL_C21] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_acc_sequencer.sv
// rtl/alu_acc_sequencer.sv - turns one ALU command into a single C-line pulse and a completion response
//
// Purpose : accepts a command in IDLE, pulses the matching ALU_ACC C-line for
//           one cycle (ISSUE), waits the op latency (WAIT), then reports
//           completion with the captured ALU flags (RESP). Illegal opcodes and
//           divide-by-zero skip straight to RESP with rsp_err set.
// Ports   : clk, rst (async, active-high)
//           cmd_valid/cmd_ready/cmd_op/br_zero - command handshake
//           alu_flags - ALU_ACC flags, captured on the last WAIT cycle
//           alu_ctrl  - one-hot C-lines, registered, high only in ISSUE
//           busy, rsp_valid, rsp_err, rsp_flags - status and response

module alu_acc_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              br_zero,
  input  logic [3:0]        alu_flags,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [3:0]        rsp_flags
);

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  cnt;
  logic [LAT_W-1:0]  cmd_lat;
  logic              accept;
  logic              cmd_legal;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic              rsp_valid_nxt;
  logic              rsp_err_nxt;
  logic              flags_load;

  always_comb begin
    cmd_lat = LAT_W'(BASE_LAT);
    if (cmd_op == OP_MUL) begin
      cmd_lat = LAT_W'(MUL_LAT);
    end else if (cmd_op == OP_DIV) begin
      cmd_lat = LAT_W'(DIV_LAT);
    end
  end

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign cmd_legal = (cmd_op <= OP_LAST) && !((cmd_op == OP_DIV) && br_zero);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = cmd_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. The C-line is loaded on the
  // accept edge so that it is high exactly during the ISSUE cycle.
  always_comb begin
    ctrl_nxt      = '0;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    flags_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_legal) begin
            ctrl_nxt = op_onehot(cmd_op);
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          rsp_valid_nxt = 1'b1;
          flags_load    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Loaded with lat-1 at accept and held through ISSUE, so WAIT lasts
  // exactly lat cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cmd_lat - LAT_W'(1);
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctrl  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_flags <= '0;
    end else begin
      alu_ctrl  <= ctrl_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      if (flags_load) begin
        rsp_flags <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// tb/tb_alu_acc_sequencer.sv - self-checking bench for alu_acc_sequencer with an ALU_ACC stand-in

module tb_alu_acc_sequencer;

  localparam int B_LAT = 1;
  localparam int M_LAT = 4;
  localparam int D_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        br_zero;
  logic [3:0]  alu_flags;
  logic [9:0]  alu_ctrl;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_err;
  logic [3:0]  rsp_flags;

  always #5 clk = ~clk;

  alu_acc_sequencer #(
    .BASE_LAT(B_LAT),
    .MUL_LAT (M_LAT),
    .DIV_LAT (D_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .br_zero  (br_zero),
    .alu_flags(alu_flags),
    .alu_ctrl (alu_ctrl),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_flags(rsp_flags)
  );

  // ALU_ACC stand-in: accumulator acts on BR when its C-line is high.
  logic [15:0] acc = 16'd0;
  logic [15:0] br;

  function automatic logic [3:0] flags_of(input logic [15:0] a);
    return {a == 16'd0, a[15], a[0], ^a};
  endfunction

  assign alu_flags = flags_of(acc);

  always @(posedge clk) begin
    case (alu_ctrl)
      10'b00_0000_0001: acc <= 16'd0;
      10'b00_0000_0010: acc <= acc + br;
      10'b00_0000_0100: acc <= acc - br;
      10'b00_0000_1000: acc <= acc * br;
      10'b00_0001_0000: acc <= (br != 16'd0) ? acc / br : acc;
      10'b00_0010_0000: acc <= acc >> 1;
      10'b00_0100_0000: acc <= acc << 1;
      10'b00_1000_0000: acc <= acc & br;
      10'b01_0000_0000: acc <= acc | br;
      10'b10_0000_0000: acc <= ~acc;
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] apply_op(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      0: return 16'd0;
      1: return a + b;
      2: return a - b;
      3: return a * b;
      4: return (b != 16'd0) ? a / b : a;
      5: return a >> 1;
      6: return a << 1;
      7: return a & b;
      8: return a | b;
      9: return ~a;
      default: return a;
    endcase
  endfunction

  // Timeline model: an op accepted in cycle t pulses in t+1 and responds in
  // t+2+lat; an error op responds in t+1. Only one op is ever outstanding.
  int          cyc = 0;
  bit          m_pend = 1'b0;
  int          m_acc_cyc, m_iss_cyc, m_resp_cyc;
  bit          m_err;
  logic [9:0]  m_ctrl;
  logic [15:0] m_acc = 16'd0;
  logic [3:0]  m_flags = 4'd0;
  logic [3:0]  m_flags_new;

  int          pulse_cnt [10];
  int          dut_accepts = 0;
  int          rsp_count = 0;
  int          last_acc_cyc = 0;
  int          last_delta = 0;
  bit          last_err = 1'b0;

  initial begin
    bit         exp_busy, exp_rv, legal;
    logic [9:0] exp_ctrl;
    int         op, lat;
    for (int i = 0; i < 10; i++) pulse_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_pend  = 1'b0;
        m_flags = 4'd0;
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
      end else begin
        exp_busy = m_pend && (cyc > m_acc_cyc);
        exp_rv   = m_pend && (cyc == m_resp_cyc);
        exp_ctrl = (m_pend && (cyc == m_iss_cyc)) ? m_ctrl : 10'd0;
        if (exp_rv && !m_err) m_flags = m_flags_new;

        check("alu_ctrl", alu_ctrl, exp_ctrl);
        check("onehot", ($countones(alu_ctrl) <= 1), 1);
        check("rsp_valid", rsp_valid, exp_rv);
        check("busy", busy, exp_busy);
        check("cmd_ready", cmd_ready, !exp_busy);
        check("rsp_flags", rsp_flags, m_flags);
        if (exp_rv) check("rsp_err", rsp_err, m_err);

        for (int i = 0; i < 10; i++) if (alu_ctrl[i]) pulse_cnt[i]++;
        if (cmd_valid && cmd_ready) begin
          dut_accepts++;
          last_acc_cyc = cyc;
        end
        if (rsp_valid) begin
          rsp_count++;
          last_delta = cyc - last_acc_cyc;
          last_err   = rsp_err;
        end

        if (exp_rv) m_pend = 1'b0;
        if (cmd_valid && !exp_busy) begin
          op    = int'(cmd_op);
          legal = (op <= 9) && !(op == 4 && br_zero);
          lat   = (op == 3) ? M_LAT : (op == 4) ? D_LAT : B_LAT;
          m_pend    = 1'b1;
          m_acc_cyc = cyc;
          m_err     = !legal;
          if (legal) begin
            m_ctrl      = 10'd1 << op;
            m_iss_cyc   = cyc + 1;
            m_resp_cyc  = cyc + 2 + lat;
            m_acc       = apply_op(op, m_acc, br);
            m_flags_new = flags_of(m_acc);
          end else begin
            m_ctrl     = 10'd0;
            m_iss_cyc  = -1;
            m_resp_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic wait_rsp();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
      if (n > 40) begin
        check("rsp_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the RESP edge.
  task automatic do_op(input int op, input logic [15:0] b, input bit brz);
    int n;
    cmd_op    = op[3:0];
    br        = b;
    br_zero   = brz;
    cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 20) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp();
    @(posedge clk);
    #1;
  endtask

  int         p [10];
  int         a0, r0;
  logic [3:0] f0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; br = 16'd0; br_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: MUL, reset in the middle of its WAIT
    cmd_op = 4'd3; br = 16'd2; br_zero = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    r0 = rsp_count;
    #2;
    check("t1_ctrl_cut", alu_ctrl, 0);
    check("t1_busy_cut", busy, 0);
    check("t1_ready_cut", cmd_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t1_no_rsp", rsp_count - r0, 0);
    check("t1_ready_after", cmd_ready, 1);

    // 2: CLR, ADD 10, ADD 5, SUB 3 -> 12
    p = pulse_cnt;
    do_op(0, 16'd0, 1'b1);   check("t2_clr_lat", last_delta, 3);
    do_op(1, 16'd10, 1'b0);  check("t2_add_lat", last_delta, 3);
    do_op(1, 16'd5, 1'b0);   check("t2_add2_lat", last_delta, 3);
    do_op(2, 16'd3, 1'b0);   check("t2_sub_lat", last_delta, 3);
    check("t2_c8_pulses", pulse_cnt[0] - p[0], 1);
    check("t2_c9_pulses", pulse_cnt[1] - p[1], 2);
    check("t2_c13_pulses", pulse_cnt[2] - p[2], 1);
    check("t2_acc", acc, 12);

    // 3: MUL 2 with MUL_LAT=4 -> 24, response 6 cycles after accept
    p = pulse_cnt;
    do_op(3, 16'd2, 1'b0);
    check("t3_c15_pulses", pulse_cnt[3] - p[3], 1);
    check("t3_lat", last_delta, 6);
    check("t3_err", last_err, 0);
    check("t3_acc", acc, 24);

    // 4: DIV by zero -> error next cycle, nothing touched
    p = pulse_cnt;
    f0 = rsp_flags;
    do_op(4, 16'd0, 1'b1);
    check("t4_lat", last_delta, 1);
    check("t4_err", last_err, 1);
    check("t4_no_pulse", pulse_cnt.sum() - p.sum(), 0);
    check("t4_acc", acc, 24);
    check("t4_flags_held", rsp_flags, f0);

    // legal DIV by 3 -> 8
    do_op(4, 16'd3, 1'b0);
    check("div_lat", last_delta, 4);
    check("div_acc", acc, 8);
    check("div_flags", rsp_flags, 4'b0001);

    // 5: illegal opcode, then SHR 8 -> 4
    do_op(12, 16'd0, 1'b0);
    check("t5_ill_lat", last_delta, 1);
    check("t5_ill_err", last_err, 1);
    do_op(5, 16'd0, 1'b0);
    check("t5_shr_err", last_err, 0);
    check("t5_acc", acc, 4);

    // 6: cmd_valid held, AND 0xFF00 then OR 0x00FF back-to-back
    a0 = dut_accepts;
    cmd_op = 4'd7; br = 16'hFF00; br_zero = 1'b0; cmd_valid = 1'b1;
    wait_rsp();
    @(posedge clk); #1 cmd_op = 4'd8; br = 16'h00FF;
    wait_rsp();
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_accepts", dut_accepts - a0, 2);
    check("t6_acc", acc, 16'h00FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
